// File: rtl/btb_pkg.sv
// Shared BTB definitions: geometry, the queued update record and the write-port controller states.
package btb_pkg;

   localparam int PC_W       = 16;
   localparam int TAG_W      = 6;
   localparam int IDX_W      = 8;
   localparam int BTB_SIZE   = 1 << IDX_W;
   localparam int FIFO_DEPTH = 4;

   // Word-aligned PCs: the two always-zero low bits are not stored.
   typedef struct packed {
      logic [PC_W-3:0] pc;
      logic [PC_W-3:0] npc;
   } btb_upd_t;

   typedef enum logic {
      S_INIT,
      S_RUN
   } btb_ctrl_state_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Synchronous update queue with a clear input. Clear has priority over push and pop.
module btb_upd_fifo
   import btb_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  btb_upd_t         din,
   output btb_upd_t         dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   btb_upd_t         mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is not reset; count alone says which slots hold valid data.
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/btb_ctrl.sv
// BTB write-port owner: sweeps every entry after reset/flush, then drains queued EX updates.
module btb_ctrl
   import btb_pkg::PC_W, btb_pkg::btb_upd_t, btb_pkg::btb_ctrl_state_t,
          btb_pkg::S_INIT, btb_pkg::S_RUN;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int BTB_SIZE   = 256,
   parameter int TAG_W      = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_req,
   output logic             init_done,
   input  logic             upd_valid,
   output logic             upd_ready,
   input  logic [PC_W-1:0]  upd_pc,
   input  logic [PC_W-1:0]  upd_npc,
   input  logic [PC_W-1:0]  fetch_pc,
   input  logic [TAG_W-1:0] btb_tag,
   input  logic [PC_W-1:0]  btb_npc,
   output logic             pred_hit,
   output logic [PC_W-1:0]  pred_npc,
   output logic             btb_we,
   output logic [PC_W-1:0]  btb_pc,
   output logic [PC_W-1:0]  btb_npc_wr
);

   localparam int IDX_W = $clog2(BTB_SIZE);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   btb_ctrl_state_t  state;
   btb_ctrl_state_t  next_state;
   logic [IDX_W-1:0] sweep_idx;
   logic [PC_W-1:0]  sweep_pc;
   logic             sweep_last;
   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   btb_upd_t         fifo_din;
   btb_upd_t         fifo_head;
   logic             unused_ok;

   assign sweep_pc   = {{(PC_W-IDX_W-2){1'b0}}, sweep_idx, 2'b00};
   assign sweep_last = (sweep_idx == IDX_W'(BTB_SIZE - 1));
   assign init_done  = (state == S_RUN);
   assign upd_ready  = init_done && !fifo_full;
   assign fifo_push  = upd_valid && upd_ready;
   assign fifo_din   = '{pc: upd_pc[PC_W-1:2], npc: upd_npc[PC_W-1:2]};
   assign unused_ok  = ^{upd_pc[1:0], upd_npc[1:0], fifo_count};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_INIT;
      else        state <= next_state;
   end

   // NOTE: defaults first so no path through this block can infer a latch.
   always_comb begin
      next_state = state;
      fifo_pop   = 1'b0;
      case (state)
         S_INIT: if (!flush_req && sweep_last) next_state = S_RUN;
         S_RUN: begin
            if (flush_req) next_state = S_INIT;
            else           fifo_pop   = !fifo_empty;
         end
         default: next_state = S_INIT;
      endcase
   end

   // A flush edge issues no write; the sweep restarts at index 0 on the following edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sweep_idx  <= '0;
         btb_we     <= 1'b0;
         btb_pc     <= '0;
         btb_npc_wr <= '0;
      end else if (flush_req) begin
         sweep_idx <= '0;
         btb_we    <= 1'b0;
      end else if (state == S_INIT) begin
         btb_we     <= 1'b1;
         btb_pc     <= sweep_pc;
         btb_npc_wr <= sweep_pc + PC_W'(4);
         sweep_idx  <= sweep_idx + IDX_W'(1);
      end else if (fifo_pop) begin
         btb_we     <= 1'b1;
         btb_pc     <= {fifo_head.pc, 2'b00};
         btb_npc_wr <= {fifo_head.npc, 2'b00};
      end else begin
         btb_we <= 1'b0;
      end
   end

   btb_upd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_upd_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (flush_req),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign pred_hit = init_done && (btb_tag == fetch_pc[PC_W-1 -: TAG_W]);
   assign pred_npc = pred_hit ? btb_npc : fetch_pc + PC_W'(4);

endmodule

// File: tb/tb_btb_ctrl.sv
// Directed bench for btb_ctrl with a behavioural BTB array and a direct test of the update queue.
module tb_btb_ctrl;
   import btb_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush_req = 1'b0;
   logic        init_done;
   logic        upd_valid = 1'b0;
   logic        upd_ready;
   logic [15:0] upd_pc = '0;
   logic [15:0] upd_npc = '0;
   logic [15:0] fetch_pc = '0;
   logic [5:0]  btb_tag;
   logic [15:0] btb_npc;
   logic        pred_hit;
   logic [15:0] pred_npc;
   logic        btb_we;
   logic [15:0] btb_pc;
   logic [15:0] btb_npc_wr;

   logic        f_clear = 1'b0;
   logic        f_push = 1'b0;
   logic        f_pop = 1'b0;
   btb_upd_t    f_din = '0;
   btb_upd_t    f_dout;
   logic        f_full;
   logic        f_empty;
   logic [2:0]  f_count;

   logic [5:0]  m_tag [256];
   logic [15:0] m_npc [256];
   logic [31:0] wlog [$];
   bit          log_en = 1'b0;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   btb_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_req  (flush_req),
      .init_done  (init_done),
      .upd_valid  (upd_valid),
      .upd_ready  (upd_ready),
      .upd_pc     (upd_pc),
      .upd_npc    (upd_npc),
      .fetch_pc   (fetch_pc),
      .btb_tag    (btb_tag),
      .btb_npc    (btb_npc),
      .pred_hit   (pred_hit),
      .pred_npc   (pred_npc),
      .btb_we     (btb_we),
      .btb_pc     (btb_pc),
      .btb_npc_wr (btb_npc_wr)
   );

   btb_upd_fifo #(.DEPTH(4)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (f_clear),
      .push  (f_push),
      .pop   (f_pop),
      .din   (f_din),
      .dout  (f_dout),
      .full  (f_full),
      .empty (f_empty),
      .count (f_count)
   );

   // Behavioural BTB: written on negedge, read combinationally by fetch_pc.
   always @(negedge clk) begin
      if (btb_we) begin
         m_tag[btb_pc[9:2]] <= btb_pc[15:10];
         m_npc[btb_pc[9:2]] <= btb_npc_wr;
         if (log_en) wlog.push_back({btb_pc, btb_npc_wr});
      end
   end
   assign btb_tag = m_tag[fetch_pc[9:2]];
   assign btb_npc = m_npc[fetch_pc[9:2]];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Follows a sweep from index 0; stops after index stop_at, or when idle in run mode.
   task automatic wait_sweep(input string tag, input int stop_at, output int nwr);
      int bad  = 0;
      int rbad = 0;
      bit done = 1'b0;
      nwr = 0;
      for (int c = 0; c < 700 && !done; c++) begin
         @(posedge clk); #1;
         if (!init_done && upd_ready) rbad++;
         if (btb_we) begin
            if (btb_pc !== 16'(nwr * 4) || btb_npc_wr !== 16'(nwr * 4 + 4)) bad++;
            nwr++;
            if (stop_at >= 0 && nwr == stop_at + 1) done = 1'b1;
         end else if (init_done) begin
            done = 1'b1;
         end
      end
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_order"}, 32'(bad), 32'd0);
      check({tag, "_ready_low"}, 32'(rbad), 32'd0);
   endtask

   task automatic fifo_step(input bit clr, input bit psh, input bit pp, input logic [27:0] d);
      f_clear = clr; f_push = psh; f_pop = pp; f_din = d;
      @(posedge clk); #1;
      f_clear = 1'b0; f_push = 1'b0; f_pop = 1'b0;
   endtask

   function automatic int log_hits(input logic [15:0] pc);
      int n = 0;
      foreach (wlog[i]) if (wlog[i][31:16] == pc) n++;
      return n;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] vpc  [5] = '{16'h1000, 16'h2104, 16'h3208, 16'h430F, 16'hFFFC};
      logic [15:0] vnpc [5] = '{16'h1100, 16'h2200, 16'h3303, 16'h4400, 16'h0000};
      logic [15:0] epc  [5] = '{16'h1000, 16'h2104, 16'h3208, 16'h430C, 16'hFFFC};
      logic [15:0] enpc [5] = '{16'h1100, 16'h2200, 16'h3300, 16'h4400, 16'h0000};
      int n;
      for (int i = 0; i < 256; i++) begin m_tag[i] = '0; m_npc[i] = '0; end

      // Reset state and the first sweep
      repeat (2) @(posedge clk); #1;
      check("rst_we", 32'(btb_we), 32'd0);
      check("rst_init_done", 32'(init_done), 32'd0);
      check("rst_ready", 32'(upd_ready), 32'd0);
      check("rst_pc", 32'(btb_pc), 32'd0);
      check("rst_npc", 32'(btb_npc_wr), 32'd0);
      rst_n = 1'b1;
      wait_sweep("sweep0", -1, n);
      check("sweep0_writes", 32'(n), 32'd256);
      check("sweep0_init_done", 32'(init_done), 32'd1);
      check("sweep0_we_idle", 32'(btb_we), 32'd0);
      check("sweep0_ready", 32'(upd_ready), 32'd1);

      // Update queue on its own: fill, push-at-full, push+pop at 2, clear
      for (int i = 0; i < 4; i++) fifo_step(1'b0, 1'b1, 1'b0, 28'(10 + i));
      check("fifo_full_count", 32'(f_count), 32'd4);
      check("fifo_full_flag", 32'(f_full), 32'd1);
      check("fifo_head_a", 32'(f_dout), 32'd10);
      fifo_step(1'b0, 1'b1, 1'b1, 28'd99);
      check("fifo_pushpop_full_count", 32'(f_count), 32'd3);
      check("fifo_head_b", 32'(f_dout), 32'd11);
      fifo_step(1'b0, 1'b0, 1'b1, 28'd0);
      fifo_step(1'b0, 1'b1, 1'b1, 28'd20);
      check("fifo_pushpop_2_count", 32'(f_count), 32'd2);
      check("fifo_head_d", 32'(f_dout), 32'd13);
      fifo_step(1'b0, 1'b0, 1'b1, 28'd0);
      check("fifo_head_f", 32'(f_dout), 32'd20);
      fifo_step(1'b0, 1'b0, 1'b1, 28'd0);
      check("fifo_empty", 32'(f_empty), 32'd1);
      fifo_step(1'b0, 1'b1, 1'b0, 28'd30);
      fifo_step(1'b1, 1'b1, 1'b0, 28'd31);
      check("fifo_clear_count", 32'(f_count), 32'd0);

      // Single update latency and prediction
      upd_valid = 1'b1; upd_pc = 16'h1234; upd_npc = 16'h2000;
      @(posedge clk); #1;
      upd_valid = 1'b0;
      check("upd_we_not_yet", 32'(btb_we), 32'd0);
      @(posedge clk); #1;
      check("upd_we", 32'(btb_we), 32'd1);
      check("upd_pc", 32'(btb_pc), 32'h1234);
      check("upd_npc", 32'(btb_npc_wr), 32'h2000);
      @(posedge clk); #1;
      check("upd_we_done", 32'(btb_we), 32'd0);
      fetch_pc = 16'h1234; #1;
      check("hit_1234", 32'(pred_hit), 32'd1);
      check("hit_1234_npc", 32'(pred_npc), 32'h2000);
      fetch_pc = 16'h5678; #1;
      check("miss_5678", 32'(pred_hit), 32'd0);
      check("miss_5678_npc", 32'(pred_npc), 32'h567C);

      // Back-to-back updates with valid held; order and low-bit masking
      wlog.delete(); log_en = 1'b1;
      upd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         upd_pc = vpc[i]; upd_npc = vnpc[i];
         check($sformatf("b2b_ready_%0d", i), 32'(upd_ready), 32'd1);
         @(posedge clk); #1;
      end
      upd_valid = 1'b0;
      repeat (3) @(posedge clk); #1;
      check("b2b_count", 32'(wlog.size()), 32'd5);
      for (int i = 0; i < 5 && i < wlog.size(); i++)
         check($sformatf("b2b_entry_%0d", i), wlog[i], {epc[i], enpc[i]});
      fetch_pc = 16'hFFFC; #1;
      check("hit_fffc", 32'(pred_hit), 32'd1);
      check("hit_fffc_npc", 32'(pred_npc), 32'h0000);

      // Flush in run mode with an in-flight write and a queued update
      wlog.delete();
      upd_valid = 1'b1; upd_pc = 16'hABC0; upd_npc = 16'h1110;
      @(posedge clk); #1;
      upd_pc = 16'hBCD0; upd_npc = 16'h2220;
      @(posedge clk); #1;
      check("inflight_pc", 32'(btb_pc), 32'hABC0);
      upd_valid = 1'b0; flush_req = 1'b1;
      @(posedge clk); #1;
      flush_req = 1'b0;
      check("flush_run_init_done", 32'(init_done), 32'd0);
      wait_sweep("sweep_partial", 100, n);
      check("sweep_partial_writes", 32'(n), 32'd101);

      // Flush during the sweep restarts from index 0
      flush_req = 1'b1;
      @(posedge clk); #1;
      flush_req = 1'b0;
      wait_sweep("sweep_restart", -1, n);
      check("sweep_restart_writes", 32'(n), 32'd256);
      check("inflight_written", 32'(log_hits(16'hABC0)), 32'd1);
      check("queued_discarded", 32'(log_hits(16'hBCD0)), 32'd0);

      // Asynchronous reset during a drain
      wlog.delete();
      upd_valid = 1'b1; upd_pc = 16'h5550; upd_npc = 16'h6660;
      @(posedge clk); #1;
      upd_valid = 1'b0;
      @(posedge clk); #1;
      check("drain_we", 32'(btb_we), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("arst_we", 32'(btb_we), 32'd0);
      check("arst_init_done", 32'(init_done), 32'd0);
      check("arst_pc", 32'(btb_pc), 32'd0);
      fetch_pc = 16'hFFFC; #1;
      check("arst_miss_fffc", 32'(pred_hit), 32'd0);
      check("arst_npc_wrap", 32'(pred_npc), 32'h0000);
      fetch_pc = 16'h0010; #1;
      check("arst_hit_gated", 32'(pred_hit), 32'd0);
      check("arst_npc_fallthru", 32'(pred_npc), 32'h0014);
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_sweep("sweep_after_rst", -1, n);
      check("sweep_after_rst_writes", 32'(n), 32'd256);
      repeat (3) @(posedge clk); #1;
      check("drain_lost", 32'(log_hits(16'h5550)), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
